bus_sram: RTL

Word-addressed synchronous SRAM slave on the main bus: the responder end of the command / write-data / read-data / error channels driven by the main interconnect. Serves fixed-length wrapping read bursts (cache-line fills, critical word first) and master-terminated write bursts with byte masks. Raises an access error for addresses beyond its capacity. Instantiated behind one interconnect slave port, typically as on-chip RAM in the dram region or as a ROM replacement for simulation.

---
 rtl/bus_sram_if.sv | 33 +++
 rtl/bus_sram.sv | 128 ++++++++++++
 2 files changed

// File: rtl/bus_sram_if.sv
// Main-bus channel bundle between the interconnect (master) and one SRAM slave port:
// command, write-data, read-data and error channels.
interface bus_sram_if;
  logic        bmain_cvalid_sram;
  logic        sram_cready;
  logic        bmain_cmd;
  logic [25:0] bmain_addr;
  logic        bmain_wvalid_sram;
  logic        sram_wready;
  logic        bmain_wlast;
  logic [31:0] bmain_wdata;
  logic [3:0]  bmain_wmask;
  logic        sram_rvalid;
  logic        bmain_rready_sram;
  logic        sram_rlast;
  logic [31:0] sram_rdata;
  logic        sram_error;
  logic        bmain_eack_sram;

  modport master (
    output bmain_cvalid_sram, bmain_cmd, bmain_addr,
    output bmain_wvalid_sram, bmain_wlast, bmain_wdata, bmain_wmask,
    output bmain_rready_sram, bmain_eack_sram,
    input  sram_cready, sram_wready, sram_rvalid, sram_rlast, sram_rdata, sram_error
  );

  modport slave (
    input  bmain_cvalid_sram, bmain_cmd, bmain_addr,
    input  bmain_wvalid_sram, bmain_wlast, bmain_wdata, bmain_wmask,
    input  bmain_rready_sram, bmain_eack_sram,
    output sram_cready, sram_wready, sram_rvalid, sram_rlast, sram_rdata, sram_error
  );
endinterface

// File: rtl/bus_sram.sv
// Word-addressed SRAM slave: wrapping critical-word-first read bursts, master-terminated
// byte-masked write bursts, and an acknowledged error path for out-of-range accesses.
module bus_sram #(
  parameter int DEPTH     = 16384,
  parameter int BURST_LEN = 4
) (
  input  logic      clk_core,
  input  logic      reset,
  bus_sram_if.slave bus
);
  localparam int             AW        = $clog2(DEPTH);
  localparam int             CW        = $clog2(BURST_LEN) + 1;
  localparam logic [AW-1:0]  WRAP_MASK = AW'(BURST_LEN - 1);
  localparam logic [CW-1:0]  LAST_BEAT = CW'(BURST_LEN - 1);
  localparam logic [CW-1:0]  BEATS     = CW'(BURST_LEN);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_WDRAIN, S_ERR} state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [31:0]   r_mem [DEPTH];
  logic [31:0]   r_buf [2];
  logic [AW-1:0] r_idx;
  logic [CW-1:0] r_issue_cnt;
  logic [CW-1:0] r_pop_cnt;
  logic [1:0]    r_count;
  logic          r_wptr;
  logic          r_rptr;

  logic          w_cready, w_wready, w_error;
  logic          w_rvalid, w_pop, w_issue, w_oor;
  logic          w_cmd_beat, w_wbeat, w_mem_we;
  logic [AW-1:0] w_idx_adv;

  assign w_oor      = (bus.bmain_addr >> AW) != 26'd0;
  assign w_cmd_beat = w_cready & bus.bmain_cvalid_sram;
  assign w_wbeat    = w_wready & bus.bmain_wvalid_sram;
  assign w_mem_we   = w_wbeat & (r_state == S_WR);
  assign w_idx_adv  = (r_idx & ~WRAP_MASK) | ((r_idx + AW'(1)) & WRAP_MASK);

  // Two-entry skid: a RAM read is launched only if its result has a free slot at the
  // edge it lands, so rvalid comes purely from r_count and never from rready.
  assign w_rvalid = (r_count != 2'd0);
  assign w_pop    = w_rvalid & bus.bmain_rready_sram;
  assign w_issue  = (r_state == S_RD) && (r_issue_cnt != BEATS) && ((r_count != 2'd2) || w_pop);

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // process samples the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (bus.bmain_cvalid_sram) begin
                  if (bus.bmain_cmd) w_state_nxt = w_oor ? S_ERR    : S_RD;
                  else               w_state_nxt = w_oor ? S_WDRAIN : S_WR;
                end
      S_RD:     if (w_pop && (r_pop_cnt == LAST_BEAT))   w_state_nxt = S_IDLE;
      S_WR:     if (bus.bmain_wvalid_sram && bus.bmain_wlast) w_state_nxt = S_IDLE;
      S_WDRAIN: if (bus.bmain_wvalid_sram && bus.bmain_wlast) w_state_nxt = S_ERR;
      S_ERR:    if (bus.bmain_eack_sram) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_cready = 1'b0;
    w_wready = 1'b0;
    w_error  = 1'b0;
    case (r_state)
      S_IDLE:            w_cready = 1'b1;
      S_WR, S_WDRAIN:    w_wready = 1'b1;
      S_ERR:             w_error  = 1'b1;
      default:           ;
    endcase
  end

  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) begin
      r_idx       <= '0;
      r_issue_cnt <= '0;
      r_pop_cnt   <= '0;
      r_count     <= '0;
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
    end else begin
      if (w_cmd_beat) begin
        r_idx       <= bus.bmain_addr[AW-1:0];
        r_issue_cnt <= '0;
        r_pop_cnt   <= '0;
      end else if (w_issue || w_mem_we) begin
        r_idx <= w_idx_adv;
      end
      if (w_issue) begin
        r_issue_cnt <= r_issue_cnt + CW'(1);
        r_wptr      <= ~r_wptr;
      end
      if (w_pop) begin
        r_pop_cnt <= r_pop_cnt + CW'(1);
        r_rptr    <= ~r_rptr;
      end
      r_count <= r_count + {1'b0, w_issue} - {1'b0, w_pop};
    end
  end

  // NOTE: the array and skid slots carry no reset so the RAM maps onto block memory;
  // rdata is gated by rvalid, so stale slot contents are never visible.
  always_ff @(posedge clk_core) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.bmain_wmask[b]) r_mem[r_idx][8*b +: 8] <= bus.bmain_wdata[8*b +: 8];
      end
    end
    if (w_issue) r_buf[r_wptr] <= r_mem[r_idx];
  end

  assign bus.sram_cready = w_cready;
  assign bus.sram_wready = w_wready;
  assign bus.sram_error  = w_error;
  assign bus.sram_rvalid = w_rvalid;
  assign bus.sram_rlast  = w_rvalid && (r_pop_cnt == LAST_BEAT);
  assign bus.sram_rdata  = w_rvalid ? r_buf[r_rptr] : 32'd0;
endmodule
